mac_dot_sequencer: RTL

Initiator-side controller for the 64-bit Vedic MAC (vedicMAC64). It accepts a dot-product job of vec_len operand pairs over a valid/ready stream and drives the MAC's clear, enable, a and b inputs. It waits out the MAC pipeline latency, captures the 128-bit accumulator and returns it on a valid/ready result port. It sits between the operand-fetch logic and the MAC and replaces hand-driven enable/reset sequencing.

---
 rtl/mac_dot_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mac_dot_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mac_dot_sequencer
// Description : Feeds a dot-product job into the Vedic MAC, waits out its
//               pipeline latency and returns the captured accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_dot_sequencer #(
    parameter int DATA_W  = 64,
    parameter int ACC_W   = 128,
    parameter int LEN_W   = 16,
    parameter int MAC_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  vec_len,
    input  logic              abort,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              mac_clr,
    output logic              mac_enable,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    input  logic [ACC_W-1:0]  mac_acc,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data
);

    localparam int DRAIN_W = $clog2(MAC_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_RUN    = 3'd2,
        S_DRAIN  = 3'd3,
        S_RESULT = 3'd4
    } state_t;

    state_t             r_state;
    logic [LEN_W-1:0]   r_remaining;
    logic [DRAIN_W-1:0] r_drain;

    assign in_ready = (r_state == S_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_drain     <= '0;
            busy        <= 1'b0;
            mac_clr     <= 1'b0;
            mac_enable  <= 1'b0;
            mac_a       <= '0;
            mac_b       <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
        end else begin
            mac_clr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (vec_len != '0) begin
                            r_remaining <= vec_len;
                            mac_clr     <= 1'b1;
                            r_state     <= S_CLEAR;
                        end else begin
                            // Empty job: answer straight away without touching the MAC.
                            res_data  <= '0;
                            res_valid <= 1'b1;
                            r_state   <= S_RESULT;
                        end
                    end
                end
                S_CLEAR: begin
                    if (abort) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        mac_enable <= 1'b0;
                        busy       <= 1'b0;
                        r_state    <= S_IDLE;
                    end else if (in_valid) begin
                        mac_a       <= in_a;
                        mac_b       <= in_b;
                        mac_enable  <= 1'b1;
                        r_remaining <= r_remaining - LEN_W'(1);
                        if (r_remaining == LEN_W'(1)) begin
                            r_drain <= DRAIN_W'(MAC_LAT);
                            r_state <= S_DRAIN;
                        end
                    end else begin
                        mac_enable <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    mac_enable <= 1'b0;
                    if (abort) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_drain == '0) begin
                        res_data  <= mac_acc;
                        res_valid <= 1'b1;
                        r_state   <= S_RESULT;
                    end else begin
                        r_drain <= r_drain - DRAIN_W'(1);
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    mac_enable <= 1'b0;
                    res_valid  <= 1'b0;
                    busy       <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
